// File: rtl/lmem_arbiter.sv
// Round-robin arbiter sharing one banked local-memory port among NUM_REQ clients,
// with bounded ownership locks and a one-cycle tagged read response.
module lmem_arbiter #(
   parameter  int unsigned NUM_REQ  = 3,
   parameter  int unsigned LOCK_MAX = 16,
   localparam int unsigned IDW      = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ-1:0]       req_we,
   input  logic [NUM_REQ-1:0]       req_is_vector,
   input  logic [NUM_REQ-1:0]       req_lock,
   input  logic [2*NUM_REQ-1:0]     req_bank_sel,
   input  logic [32*NUM_REQ-1:0]    req_addr,
   input  logic [128*NUM_REQ-1:0]   req_wdata,
   output logic                     mem_req_valid,
   output logic                     mem_req_we,
   output logic                     mem_req_is_vector,
   output logic [1:0]               mem_req_bank_sel,
   output logic [31:0]              mem_req_addr,
   output logic [127:0]             mem_req_wdata,
   input  logic [127:0]             mem_rdata,
   output logic                     rsp_valid,
   output logic [IDW-1:0]           rsp_id,
   output logic [127:0]             rsp_rdata,
   output logic [31:0]              rsp_word
);

   localparam int unsigned CW = $clog2(LOCK_MAX + 1);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
   logic [1:0]       bank_q;
   logic [IDW-1:0]   cand;
   logic [IDW-1:0]   win;
   logic             found;
   logic [NUM_REQ-1:0] grant;

   function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
      return (v == IDW'(NUM_REQ - 1)) ? '0 : v + IDW'(1);
   endfunction

   // Winner selection and lock bookkeeping
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      cand       = '0;
      win        = '0;
      found      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
               cand = IDW'((int'(ptr_q) + k) % int'(NUM_REQ));
               if (!found && req_valid[cand]) begin
                  found = 1'b1;
                  win   = cand;
               end
            end
            if (found) begin
               ptr_d = inc_wrap(win);
               if (req_lock[win] && (LOCK_MAX > 1)) begin
                  state_d    = S_LOCKED;
                  owner_d    = win;
                  lock_cnt_d = CW'(1);
               end
            end
         end
         S_LOCKED: begin
            if (req_valid[owner_q]) begin
               found = 1'b1;
               win   = owner_q;
            end
            lock_cnt_d = lock_cnt_q + CW'(1);
            // Release on an unlocked owner beat, or once this cycle completes LOCK_MAX owned cycles
            if ((found && !req_lock[owner_q]) || (lock_cnt_d == CW'(LOCK_MAX))) begin
               state_d    = S_IDLE;
               ptr_d      = inc_wrap(owner_q);
               lock_cnt_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      grant = found ? (NUM_REQ'(1) << win) : '0;
   end

   // Forward the granted request's fields; all zero when nothing is granted
   always_comb begin
      mem_req_we        = 1'b0;
      mem_req_is_vector = 1'b0;
      mem_req_bank_sel  = '0;
      mem_req_addr      = '0;
      mem_req_wdata     = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (grant[i]) begin
            mem_req_we        = req_we[i];
            mem_req_is_vector = req_is_vector[i];
            mem_req_bank_sel  = req_bank_sel[2*i +: 2];
            mem_req_addr      = req_addr[32*i +: 32];
            mem_req_wdata     = req_wdata[128*i +: 128];
         end
      end
   end

   assign req_ready     = grant;
   assign mem_req_valid = |grant;
   assign rsp_rdata     = mem_rdata;
   assign rsp_word      = mem_rdata[{bank_q, 5'd0} +: 32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         bank_q     <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         rsp_valid  <= mem_req_valid & ~mem_req_we;
         if (mem_req_valid && !mem_req_we) begin
            rsp_id <= win;
            bank_q <= mem_req_bank_sel;
         end
      end
   end

endmodule
